async_fifo_fwft: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 16 +
 rtl/gray_sync.sv | 23 ++
 rtl/async_fifo_fwft.sv | 123 ++++++++++++
 tb/tb_async_fifo_fwft.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared Gray-code helpers and read-mode constants for the dual-clock FIFO
package async_fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] m;
    m = b & ((32'd1 << w) - 32'd1);
    return m ^ (m >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = g & ((32'd1 << w) - 32'd1);
    for (int i = 30; i >= 0; i--) b[i] = b[i] ^ b[i+1];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchroniser for a Gray-coded pointer crossing into clk
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  // shift the incoming pointer one stage deeper each edge
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  // synchroniser flops, cleared to pointer value 0 on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '{default: '0};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_fwft.sv
// async_fifo_fwft: dual-clock Gray-pointer FIFO with optional first-word-fall-through read port
module async_fifo_fwft import async_fifo_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  wr_clr_err,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_ready,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  rd_clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] rd_count,
  output logic                  underflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic FW = (FWFT == FIFO_MODE_FWFT);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_gray_wsync, wr_count_q, wr_count_d;
  logic full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d, wr_acc;
  logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_gray_rsync, rd_occ;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, ram_empty_q, ram_empty_d, almost_empty_q, almost_empty_d;
  logic underflow_q, underflow_d, ram_avail, pop;
  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2wr (
    .clk(wr_clk), .rst_n(wr_rst_n), .d(rd_gray_q), .q(rd_gray_wsync)
  );
  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr2rd (
    .clk(rd_clk), .rst_n(rd_rst_n), .d(wr_gray_q), .q(wr_gray_rsync)
  );
  // write side: accept, advance pointer, derive flags from the post-write pointer
  always_comb begin
    wr_acc = wr_en & ~full_q;
    wr_bin_d = wr_bin_q + PW'(wr_acc);
    wr_gray_d = PW'(bin2gray(32'(wr_bin_d), PW));
    full_d = wr_gray_d == {~rd_gray_wsync[PW-1:PW-2], rd_gray_wsync[PW-3:0]};
    wr_count_d = wr_bin_d - PW'(gray2bin(32'(rd_gray_wsync), PW));
    almost_full_d = wr_count_d >= af_thresh;
    overflow_d = ~wr_clr_err & (overflow_q | (wr_en & full_q));
  end
  // write-domain state
  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      wr_bin_q <= '0;
      wr_gray_q <= '0;
      full_q <= 1'b0;
      almost_full_q <= 1'b0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q <= full_d;
      almost_full_q <= almost_full_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
    end
  // RAM write port; contents need no reset since pointers gate every read
  always_ff @(posedge wr_clk)
    if (wr_acc) mem[wr_bin_q[ADDR_WIDTH-1:0]] <= wr_data;
  // read side: FWFT refills the output register as soon as the synced pointer shows data,
  // standard mode pops only on a request against the registered (pessimistic) empty
  always_comb begin
    ram_avail = rd_gray_q != wr_gray_rsync;
    pop = FW ? ram_avail & (~rd_valid_q | rd_ready) : rd_ready & ~ram_empty_q;
    rd_bin_d = rd_bin_q + PW'(pop);
    rd_gray_d = PW'(bin2gray(32'(rd_bin_d), PW));
    ram_empty_d = rd_gray_d == wr_gray_rsync;
    rd_data_d = pop ? mem[rd_bin_q[ADDR_WIDTH-1:0]] : rd_data_q;
    rd_valid_d = FW ? pop | (rd_valid_q & ~rd_ready) : pop;
    rd_occ = PW'(gray2bin(32'(wr_gray_rsync), PW)) - rd_bin_d;
    rd_count_d = {1'b0, rd_occ} + CW'(FW & rd_valid_d);
    almost_empty_d = rd_count_d <= CW'(ae_thresh);
    underflow_d = ~rd_clr_err & (underflow_q | (~FW & rd_ready & ram_empty_q));
  end
  // read-domain state
  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      rd_bin_q <= '0;
      rd_gray_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ram_empty_q <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_count_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ram_empty_q <= ram_empty_d;
      almost_empty_q <= almost_empty_d;
      rd_count_q <= rd_count_d;
      underflow_q <= underflow_d;
    end
  assign full = full_q;
  assign almost_full = almost_full_q;
  assign wr_count = wr_count_q;
  assign overflow = overflow_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty = FW ? ~rd_valid_q : ram_empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count = rd_count_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_async_fifo_fwft.sv
// tb_async_fifo_fwft: table-driven flag vectors, directed corner sequences and a data scoreboard
module tb_async_fifo_fwft;
  logic wr_clk = 1'b0, rd_clk = 1'b0, wr_rst_n = 1'b0, rd_rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic wr_en = 1'b0, rd_ready = 1'b0, wr_clr_err = 1'b0, rd_clr_err = 1'b0;
  logic [4:0] af_thresh = 5'd16, ae_thresh = 5'd0;
  logic full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
  logic [4:0] wr_count;
  logic [5:0] rd_count;
  logic [15:0] rd_data;
  logic s_full, s_almost_full, s_overflow, s_rd_valid, s_empty, s_almost_empty, s_underflow;
  logic [4:0] s_wr_count;
  logic [5:0] s_rd_count;
  logic [15:0] s_rd_data;
  int rd_half = 6850;
  int total = 0, bad = 0, n_push = 0, n_pop = 0;
  bit chk_on = 1'b0, wr_done = 1'b0, hi_phase = 1'b0;
  logic [15:0] sb [$];
  typedef struct {
    int n;
    logic [4:0] af_t;
    logic [4:0] ae_t;
    logic ex_full;
    logic ex_af;
    logic [4:0] ex_wc;
    logic [5:0] ex_rc;
    logic ex_ae;
  } vec_t;
  vec_t vt [7];

  always #5000 wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SYNC_STAGES(2), .FWFT(1)) u_fwft (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_data(wr_data), .wr_en(wr_en), .af_thresh(af_thresh), .wr_clr_err(wr_clr_err),
    .full(full), .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow),
    .rd_ready(rd_ready), .ae_thresh(ae_thresh), .rd_clr_err(rd_clr_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );
  async_fifo_fwft #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SYNC_STAGES(2), .FWFT(0)) u_std (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_data(wr_data), .wr_en(wr_en), .af_thresh(af_thresh), .wr_clr_err(wr_clr_err),
    .full(s_full), .almost_full(s_almost_full), .wr_count(s_wr_count), .overflow(s_overflow),
    .rd_ready(rd_ready), .ae_thresh(ae_thresh), .rd_clr_err(rd_clr_err),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_almost_empty),
    .rd_count(s_rd_count), .underflow(s_underflow)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // scoreboard producer: every write the FWFT FIFO should accept
  always @(posedge wr_clk)
    if (wr_rst_n && wr_en && !full) begin
      sb.push_back(wr_data);
      n_push++;
    end

  // scoreboard consumer: every word the FWFT FIFO hands over
  always @(posedge rd_clk)
    if (rd_rst_n && rd_valid && rd_ready) begin
      chk("sb nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("sb data", 32'(rd_data), 32'(sb.pop_front()));
      n_pop++;
    end

  // threshold/count invariants in the write domain
  always @(negedge wr_clk)
    if (chk_on) begin
      chk("af vs wr_count", 32'(almost_full), 32'(wr_count >= af_thresh));
      chk("wr_count max", 32'(wr_count <= 5'd16), 1);
    end

  // threshold/count invariants in the read domain
  always @(negedge rd_clk)
    if (chk_on) begin
      chk("ae vs rd_count", 32'(almost_empty), 32'(rd_count <= {1'b0, ae_thresh}));
      chk("rd_count max", 32'(rd_count <= 6'd17), 1);
    end

  task automatic chk_reset();
    chk("rst full", 32'(full), 0);
    chk("rst almost_full", 32'(almost_full), 0);
    chk("rst wr_count", 32'(wr_count), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst almost_empty", 32'(almost_empty), 1);
    chk("rst rd_count", 32'(rd_count), 0);
    chk("rst underflow", 32'(underflow), 0);
    chk("rst std empty", 32'(s_empty), 1);
    chk("rst std rd_valid", 32'(s_rd_valid), 0);
    chk("rst std overflow", 32'(s_overflow), 0);
    chk("rst std underflow", 32'(s_underflow), 0);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_ready = 1'b0;
    rd_clr_err = 1'b0;
    @(negedge wr_clk);
    wr_en = 1'b0;
    wr_clr_err = 1'b0;
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    repeat (5) @(negedge wr_clk);
    repeat (5) @(negedge rd_clk);
    sb.delete();
    chk_reset();
    @(negedge rd_clk);
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);
  endtask

  task automatic wr_burst(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1;
      wr_data = base + 16'(i);
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int t;
    vt[0] = '{0,  5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  6'd0,  1'b1};
    vt[1] = '{1,  5'd1,  5'd0,  1'b0, 1'b0, 5'd0,  6'd1,  1'b0};
    vt[2] = '{5,  5'd4,  5'd5,  1'b0, 1'b1, 5'd4,  6'd5,  1'b1};
    vt[3] = '{5,  5'd5,  5'd4,  1'b0, 1'b0, 5'd4,  6'd5,  1'b0};
    vt[4] = '{17, 5'd16, 5'd17, 1'b1, 1'b1, 5'd16, 6'd17, 1'b1};
    vt[5] = '{9,  5'd8,  5'd31, 1'b0, 1'b1, 5'd8,  6'd9,  1'b1};
    vt[6] = '{3,  5'd31, 5'd2,  1'b0, 1'b0, 5'd2,  6'd3,  1'b0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      af_thresh = vt[k].af_t;
      ae_thresh = vt[k].ae_t;
      do_reset();
      if (vt[k].n > 0) begin
        wr_burst(1, 16'h0100);
        repeat (10) @(negedge wr_clk);
        wr_burst(vt[k].n - 1, 16'h0101);
      end
      repeat (30) @(negedge wr_clk);
      chk($sformatf("v%0d full", k), 32'(full), 32'(vt[k].ex_full));
      chk($sformatf("v%0d almost_full", k), 32'(almost_full), 32'(vt[k].ex_af));
      chk($sformatf("v%0d wr_count", k), 32'(wr_count), 32'(vt[k].ex_wc));
      chk($sformatf("v%0d rd_count", k), 32'(rd_count), 32'(vt[k].ex_rc));
      chk($sformatf("v%0d almost_empty", k), 32'(almost_empty), 32'(vt[k].ex_ae));
    end
    af_thresh = 5'd16;
    ae_thresh = 5'd0;
    do_reset();
    wr_burst(1, 16'h0001);
    t = 0;
    while (!rd_valid && t < 50) begin
      @(negedge rd_clk);
      t++;
    end
    chk("first word loaded", 32'(t < 50), 1);
    repeat (8) @(negedge wr_clk);
    wr_burst(16, 16'h0002);
    chk("full after 17", 32'(full), 1);
    chk("wr_count at full", 32'(wr_count), 16);
    chk("no overflow yet", 32'(overflow), 0);
    wr_burst(1, 16'h0012);
    chk("overflow set", 32'(overflow), 1);
    chk("full still", 32'(full), 1);
    wr_clr_err = 1'b1;
    @(negedge wr_clk);
    wr_clr_err = 1'b0;
    @(negedge wr_clk);
    chk("overflow cleared", 32'(overflow), 0);
    chk("rd_count 17", 32'(rd_count), 17);
    n_pop = 0;
    @(negedge rd_clk);
    rd_ready = 1'b1;
    t = 0;
    while ((sb.size() != 0 || !empty) && t < 200) begin
      @(negedge rd_clk);
      t++;
    end
    rd_ready = 1'b0;
    chk("drain in time", 32'(t < 200), 1);
    chk("drain count", 32'(n_pop), 17);
    chk("empty after drain", 32'(empty), 1);
    chk("rd_count after drain", 32'(rd_count), 0);
    do_reset();
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_data = 16'hBEEF;
    @(posedge wr_clk);
    #1 wr_en = 1'b0;
    t = 0;
    while (!rd_valid && t < 20) begin
      @(posedge rd_clk);
      #1 t++;
    end
    chk("beef latency", 32'(t >= 3 && t <= 4), 1);
    chk("beef data", 32'(rd_data), 32'h0000BEEF);
    chk("beef rd_count", 32'(rd_count), 1);
    chk("beef not empty", 32'(empty), 0);
    do_reset();
    @(negedge rd_clk);
    rd_ready = 1'b1;
    @(negedge rd_clk);
    rd_ready = 1'b0;
    chk("std underflow set", 32'(s_underflow), 1);
    chk("std empty", 32'(s_empty), 1);
    chk("std rd_valid idle", 32'(s_rd_valid), 0);
    chk("std rd_count 0", 32'(s_rd_count), 0);
    chk("fwft no underflow", 32'(underflow), 0);
    rd_clr_err = 1'b1;
    @(negedge rd_clk);
    rd_clr_err = 1'b0;
    @(negedge rd_clk);
    chk("std underflow cleared", 32'(s_underflow), 0);
    wr_burst(1, 16'hA5A5);
    t = 0;
    while (s_empty && t < 20) begin
      @(negedge rd_clk);
      t++;
    end
    chk("std fill in time", 32'(t < 20), 1);
    chk("std rd_count 1", 32'(s_rd_count), 1);
    rd_ready = 1'b1;
    @(negedge rd_clk);
    rd_ready = 1'b0;
    chk("std pop valid", 32'(s_rd_valid), 1);
    chk("std pop data", 32'(s_rd_data), 32'h0000A5A5);
    chk("std empty after pop", 32'(s_empty), 1);
    chk("std no underflow on pop", 32'(s_underflow), 0);
    @(negedge rd_clk);
    chk("std valid one cycle", 32'(s_rd_valid), 0);
    do_reset();
    wr_burst(9, 16'h0300);
    repeat (20) @(negedge wr_clk);
    chk("nine held", 32'(rd_count), 9);
    do_reset();
    wr_burst(1, 16'h1234);
    t = 0;
    while (!rd_valid && t < 50) begin
      @(negedge rd_clk);
      t++;
    end
    chk("post-reset word in time", 32'(t < 50), 1);
    chk("post-reset first word", 32'(rd_data), 32'h00001234);
    rd_half = 1667;
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    do_reset();
    chk_on = 1'b1;
    wr_done = 1'b0;
    fork
      begin : rnd_wr
        for (int i = 0; i < 800; i++) begin
          @(negedge wr_clk);
          hi_phase = (i < 400);
          wr_en = ($urandom_range(0, 99) < (hi_phase ? 75 : 25));
          wr_data = 16'($urandom);
        end
        wr_en = 1'b0;
        wr_done = 1'b1;
      end
      begin : rnd_rd
        while (!wr_done) begin
          @(negedge rd_clk);
          rd_ready = ($urandom_range(0, 99) < (hi_phase ? 15 : 60));
        end
        rd_ready = 1'b0;
      end
    join
    chk_on = 1'b0;
    rd_half = 6850;
    af_thresh = 5'd16;
    ae_thresh = 5'd0;
    do_reset();
    n_push = 0;
    n_pop = 0;
    fork
      begin : bulk_wr
        int tw;
        tw = 0;
        while (n_push < 10000 && tw < 40000) begin
          @(negedge wr_clk);
          tw++;
          wr_en = !full && ($urandom_range(0, 99) < 95);
          wr_data = 16'($urandom);
        end
        wr_en = 1'b0;
      end
      begin : bulk_rd
        int tr;
        tr = 0;
        while (n_pop < 10000 && tr < 40000) begin
          @(negedge rd_clk);
          tr++;
          rd_ready = ($urandom_range(0, 99) < 95);
        end
        rd_ready = 1'b0;
      end
    join
    repeat (10) @(negedge rd_clk);
    chk("bulk pushed", 32'(n_push), 10000);
    chk("bulk popped", 32'(n_pop), 10000);
    chk("bulk sb empty", 32'(sb.size()), 0);
    chk("bulk no overflow", 32'(overflow), 0);
    chk("bulk empty", 32'(empty), 1);
    chk("bulk rd_count", 32'(rd_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
